// File: rtl/sync_up_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sync_up_pkg
//  Description : Shared definitions for the synchronous up-counter family.
//                Holds the default geometry (WIDTH/MODULUS) and the per-edge
//                operation decode used by the counter top level.
//  Revision    : 1.0  initial release
// ============================================================================
package sync_up_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_MODULUS = 16;

  // What the counter does on the next rising edge.
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_INC  = 2'd1,
    OP_WRAP = 2'd2,
    OP_LOAD = 2'd3
  } op_e;

  // Priority is load > enable > hold; an enabled count at the top value
  // becomes a wrap rather than a plain increment.
  function automatic op_e decode_op(input logic load, input logic en,
                                    input logic at_max);
    op_e op;
    op = OP_HOLD;
    if (load)        op = OP_LOAD;
    else if (en)     op = at_max ? OP_WRAP : OP_INC;
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_up_bit.sv
`default_nettype none
// ============================================================================
//  Module      : sync_up_bit
//  Description : One T-style counter stage. Toggles when i_tog is high,
//                takes i_d when i_ld is high (load has priority), and clears
//                asynchronously while rst is low.
//  Ports       : clk   - clock, rising edge
//                rst   - asynchronous clear, active low
//                i_tog - toggle enable (count enable AND all lower bits 1)
//                i_ld  - synchronous load strobe
//                i_d   - load value
//                o_q   - registered stage output
//  Revision    : 1.0  initial release
// ============================================================================
module sync_up_bit (
  input  logic clk,
  input  logic rst,
  input  logic i_tog,
  input  logic i_ld,
  input  logic i_d,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= 1'b0;
    end else if (i_ld) begin
      r_q <= i_d;
    end else if (i_tog) begin
      r_q <= ~r_q;
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/sync_up.sv
`default_nettype none
// ============================================================================
//  Module      : sync_up
//  Description : Synchronous modulo-MODULUS up-counter with parallel load
//                (saturating at MODULUS-1), cascadable terminal count and a
//                sticky wrap flag.
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous reset, active low
//                en   - count enable
//                load - synchronous parallel load strobe (beats en)
//                dIn  - parallel load value
//                qOut - current count, registered
//                tc   - terminal count (qOut == MODULUS-1 and en), combinational
//                ovf  - sticky wrap flag, cleared by load or reset
//  Revision    : 1.0  initial release
// ============================================================================
module sync_up
  import sync_up_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] dIn,
  output logic [WIDTH-1:0] qOut,
  output logic             tc,
  output logic             ovf
);

  // Top legal count; also the saturation value for out-of-range loads.
  localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MODULUS - 1);

  logic             w_at_max;
  op_e              w_op;
  logic             w_ld;
  logic [WIDTH-1:0] w_ld_val;
  logic             w_inc;
  logic [WIDTH-1:0] w_carry;
  logic             r_ovf;

  assign w_at_max = (qOut == c_MAX);
  assign w_op     = decode_op(load, en, w_at_max);

  // A wrap is realised as a synchronous load of zero, so the stages only
  // ever see a plain binary increment below c_MAX and the count can never
  // step past MODULUS-1.
  assign w_ld     = (w_op == OP_LOAD) || (w_op == OP_WRAP);
  assign w_ld_val = (w_op == OP_LOAD) ? ((dIn > c_MAX) ? c_MAX : dIn) : '0;
  assign w_inc    = (w_op == OP_INC);

  // Ripple of "all lower bits are one" feeding each stage's toggle.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    if (i == 0) begin : g_lsb
      assign w_carry[i] = w_inc;
    end else begin : g_upper
      assign w_carry[i] = w_carry[i-1] & qOut[i-1];
    end

    sync_up_bit u_bit (
      .clk   (clk),
      .rst   (rst),
      .i_tog (w_carry[i]),
      .i_ld  (w_ld),
      .i_d   (w_ld_val[i]),
      .o_q   (qOut[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else begin
      case (w_op)
        OP_LOAD: r_ovf <= 1'b0;
        OP_WRAP: r_ovf <= 1'b1;
        default: r_ovf <= r_ovf;
      endcase
    end
  end

  assign ovf = r_ovf;

  // Cascade output: high in the cycle whose edge will wrap this stage.
  assign tc = w_at_max & en;

endmodule
`default_nettype wire

// File: tb/tb_sync_up.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_up
//  Description : Self-checking bench for sync_up. Runs a MODULUS=16 and a
//                MODULUS=10 instance side by side on shared stimulus and
//                compares both against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sync_up;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] dIn;
  logic [3:0] q16, q10;
  logic       tc16, tc10, ovf16, ovf10;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: index 0 is the modulus-16 counter, 1 the modulus-10.
  int m_q[2];
  int m_ovf[2];
  int mods[2];

  always #5 clk = ~clk;

  sync_up #(.WIDTH(4), .MODULUS(16)) u_dut16 (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .load (load),
    .dIn  (dIn),
    .qOut (q16),
    .tc   (tc16),
    .ovf  (ovf16)
  );

  sync_up #(.WIDTH(4), .MODULUS(10)) u_dut10 (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .load (load),
    .dIn  (dIn),
    .qOut (q10),
    .tc   (tc10),
    .ovf  (ovf10)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state();
    check_eq("q16",   32'(q16),   32'(m_q[0]));
    check_eq("ovf16", 32'(ovf16), 32'(m_ovf[0]));
    check_eq("q10",   32'(q10),   32'(m_q[1]));
    check_eq("ovf10", 32'(ovf10), 32'(m_ovf[1]));
  endtask

  task automatic check_tc();
    check_eq("tc16", 32'(tc16), 32'((m_q[0] == mods[0] - 1) && en));
    check_eq("tc10", 32'(tc10), 32'((m_q[1] == mods[1] - 1) && en));
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (load) begin
        m_q[k]   = (int'(dIn) > mods[k] - 1) ? mods[k] - 1 : int'(dIn);
        m_ovf[k] = 0;
      end else if (en) begin
        if (m_q[k] == mods[k] - 1) begin
          m_q[k]   = 0;
          m_ovf[k] = 1;
        end else begin
          m_q[k] = m_q[k] + 1;
        end
      end
    end
  endtask

  // Drive inputs just after an edge, check tc, then check state after the edge.
  task automatic step(input logic e, input logic l, input logic [3:0] d);
    en   = e;
    load = l;
    dIn  = d;
    #1;
    check_tc();
    @(posedge clk);
    model_edge();
    #1;
    check_state();
  endtask

  // Pulse reset between edges; outputs must clear without a clock.
  task automatic async_reset();
    #2;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_q[k]   = 0;
      m_ovf[k] = 0;
    end
    #1;
    check_state();
    check_tc();
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst  = 1'b0;
    en   = 1'b0;
    load = 1'b0;
    dIn  = 4'h0;
    mods[0] = 16;
    mods[1] = 10;
    for (int k = 0; k < 2; k++) begin
      m_q[k]   = 0;
      m_ovf[k] = 0;
    end

    #2;
    check_state();
    check_tc();
    #10;
    rst = 1'b1;

    // Free run: 20 enabled edges.
    repeat (20) step(1'b1, 1'b0, 4'h0);
    check_eq("run16_end",    32'(q16),   32'd4);
    check_eq("run16_ovf",    32'(ovf16), 32'd1);
    check_eq("run10_end",    32'(q10),   32'd0);
    check_eq("run10_ovf",    32'(ovf10), 32'd1);

    // Out-of-range load saturates on the modulus-10 counter, then wraps.
    step(1'b0, 1'b1, 4'hC);
    check_eq("sat10_q",      32'(q10),   32'd9);
    check_eq("sat10_ovf",    32'(ovf10), 32'd0);
    check_eq("sat16_q",      32'(q16),   32'd12);
    step(1'b1, 1'b0, 4'h0);
    check_eq("sat10_wrap_q", 32'(q10),   32'd0);
    check_eq("sat10_wrap_o", 32'(ovf10), 32'd1);
    check_eq("sat16_inc_q",  32'(q16),   32'd13);

    // Load and enable together at terminal count: load wins.
    step(1'b0, 1'b1, 4'hF);
    step(1'b1, 1'b1, 4'h3);
    check_eq("ldtc16_q",     32'(q16),   32'd3);
    check_eq("ldtc16_ovf",   32'(ovf16), 32'd0);

    // Enable pattern 1,0,0,1 from 5.
    step(1'b0, 1'b1, 4'h5);
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 4'h0);
    check_eq("enpat16_q",    32'(q16),   32'd7);
    check_eq("enpat10_q",    32'(q10),   32'd7);

    // Count to 7, reset between edges, first enabled edge gives 1.
    step(1'b0, 1'b1, 4'h0);
    repeat (7) step(1'b1, 1'b0, 4'h0);
    check_eq("pre_rst16_q",  32'(q16),   32'd7);
    async_reset();
    step(1'b1, 1'b0, 4'h0);
    check_eq("post_rst16_q", 32'(q16),   32'd1);
    check_eq("post_rst10_q", 32'(q10),   32'd1);

    // Randomised traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 4'($urandom));
      if ($urandom_range(0, 39) == 0) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
